// File: rtl/riscv_hwloop_jump_ctrl_if.sv
`default_nettype none
// ============================================================================
// | Module      : riscv_hwloop_jump_ctrl_if                                  |
// | Description : Bundle of the signals exchanged between the IF/ID stages,  |
// |               the hardware-loop register file and the hardware-loop      |
// |               jump controller.                                           |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
// Port summary (direction seen from the controller, modport slave):
//   current_pc_i       in   PC being fetched in IF
//   if_valid_i         in   fetch at current_pc_i accepted this cycle
//   id_valid_i         in   instruction in ID retires this cycle
//   flush_i            in   branch/exception kill, drops pending tokens
//   hwlp_start_addr_i  in   per-loop start address
//   hwlp_end_addr_i    in   per-loop end address
//   hwlp_counter_i     in   per-loop current count
//   hwlp_cnt_we_i      in   a loop counter is written this cycle
//   hwlp_regid_i       in   index of the loop whose counter is written
//   hwlp_jump_o        out  redirect fetch to hwlp_targ_addr_o
//   hwlp_targ_addr_o   out  start address of the winning loop
//   hwlp_dec_cnt_o     out  one-hot decrement request to the loop registers
//   hwlp_stall_o       out  token FIFO full, IF must hold
//   hwlp_jump_cnt_o    out  count of taken loop jumps (0 when not enabled)
// The master modport is the core/register-file side driving the controller.
// ============================================================================
interface riscv_hwloop_jump_ctrl_if #(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
);
  logic [31:0]              current_pc_i;
  logic                     if_valid_i;
  logic                     id_valid_i;
  logic                     flush_i;
  logic [N_REGS-1:0][31:0]  hwlp_start_addr_i;
  logic [N_REGS-1:0][31:0]  hwlp_end_addr_i;
  logic [N_REGS-1:0][31:0]  hwlp_counter_i;
  logic                     hwlp_cnt_we_i;
  logic [N_REG_BITS-1:0]    hwlp_regid_i;
  logic                     hwlp_jump_o;
  logic [31:0]              hwlp_targ_addr_o;
  logic [N_REGS-1:0]        hwlp_dec_cnt_o;
  logic                     hwlp_stall_o;
  logic [31:0]              hwlp_jump_cnt_o;

  modport master (
    output current_pc_i, if_valid_i, id_valid_i, flush_i,
           hwlp_start_addr_i, hwlp_end_addr_i, hwlp_counter_i,
           hwlp_cnt_we_i, hwlp_regid_i,
    input  hwlp_jump_o, hwlp_targ_addr_o, hwlp_dec_cnt_o,
           hwlp_stall_o, hwlp_jump_cnt_o
  );

  modport slave (
    input  current_pc_i, if_valid_i, id_valid_i, flush_i,
           hwlp_start_addr_i, hwlp_end_addr_i, hwlp_counter_i,
           hwlp_cnt_we_i, hwlp_regid_i,
    output hwlp_jump_o, hwlp_targ_addr_o, hwlp_dec_cnt_o,
           hwlp_stall_o, hwlp_jump_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/riscv_hwloop_jump_ctrl.sv
`default_nettype none
// ============================================================================
// | Module      : riscv_hwloop_jump_ctrl                                     |
// | Description : Hardware-loop jump controller. Matches the fetch PC        |
// |               against each loop end address, redirects fetch to the      |
// |               loop start and queues one decrement token per end-of-body  |
// |               fetch. Tokens are released to the loop register file only  |
// |               when the matching instruction retires from ID.             |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
// Ports:
//   clk  in   clock
//   rst  in   asynchronous active-high reset
//   bus  slave modport of riscv_hwloop_jump_ctrl_if (see interface header)
// Parameters:
//   N_REGS      number of hardware loops (index 0 = innermost, highest prio)
//   N_REG_BITS  width of the loop index
//   FIFO_DEPTH  number of pending decrement tokens (fetch run-ahead)
// Optional feature:
//   RISCV_HWLP_PERF_EN  when defined, hwlp_jump_cnt_o counts taken jumps;
//                       otherwise it is tied to 0.
// ============================================================================
module riscv_hwloop_jump_ctrl #(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1,
  parameter int FIFO_DEPTH = 2
) (
  input wire logic                  clk,
  input wire logic                  rst,
  riscv_hwloop_jump_ctrl_if.slave   bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_PART  = 2'd1,
    ST_FULL  = 2'd2
  } tok_state_e;

  // Token FIFO: entries [0 .. cnt_q-1] are valid, entry 0 is the head.
  tok_state_e               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [N_REG_BITS-1:0]    tag_q [FIFO_DEPTH];
  logic [N_REG_BITS-1:0]    tag_d [FIFO_DEPTH];

  logic [FIFO_DEPTH-1:0]        entry_valid;
  logic [FIFO_DEPTH-1:0]        entry_keep;
  logic [N_REGS-1:0][CNT_W-1:0] pend;
  logic [N_REGS-1:0][31:0]      eff;
  logic [N_REGS-1:0]            match;
  logic [N_REG_BITS-1:0]        win;
  logic                         any_match;
  logic [31:0]                  eff_win;
  logic                         fifo_empty;
  logic                         fifo_full;
  logic                         stall_raw;
  logic                         do_pop;
  logic                         do_push;
  logic                         push_keep;
  logic                         jump;
  logic [CNT_W-1:0]             fill_cnt;

  // --------------------------------------------------------------------------
  // Effective loop counts: the register-file count minus tokens still in
  // flight for that loop, saturating at zero.
  // --------------------------------------------------------------------------
  always_comb begin
    entry_valid = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      entry_valid[i] = (cnt_q > CNT_W'(i));
    end
  end

  always_comb begin
    pend = '0;
    for (int k = 0; k < N_REGS; k++) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (entry_valid[i] && (tag_q[i] == N_REG_BITS'(k))) begin
          pend[k] = pend[k] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    eff   = '0;
    match = '0;
    for (int k = 0; k < N_REGS; k++) begin
      if (bus.hwlp_counter_i[k] >= 32'(pend[k])) begin
        eff[k] = bus.hwlp_counter_i[k] - 32'(pend[k]);
      end
      match[k] = (eff[k] != 32'd0) && (bus.current_pc_i == bus.hwlp_end_addr_i[k]);
    end
  end

  // Lowest matching index wins: scan downwards so the last hit is the lowest.
  always_comb begin
    win = '0;
    for (int k = N_REGS - 1; k >= 0; k--) begin
      if (match[k]) begin
        win = N_REG_BITS'(k);
      end
    end
  end

  assign any_match = |match;
  assign eff_win   = eff[win];

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  assign fifo_empty = (state_q == ST_EMPTY);
  assign fifo_full  = (state_q == ST_FULL);

  // A retiring instruction frees the head slot in the same cycle, so a full
  // FIFO only stalls fetch when nothing retires.
  assign stall_raw = fifo_full & ~bus.id_valid_i;
  assign do_pop    = bus.id_valid_i & ~fifo_empty;
  assign do_push   = bus.if_valid_i & any_match & ~stall_raw;
  // A token for a loop whose counter is being rewritten would decrement the
  // fresh value, so it is discarded like the queued ones.
  assign push_keep = do_push & ~(bus.hwlp_cnt_we_i && (win == bus.hwlp_regid_i));

  // On the last iteration (eff == 1) no jump is taken but the token is still
  // pushed, which brings the counter to zero.
  assign jump = ~rst & bus.if_valid_i & any_match & (eff_win > 32'd1);

  assign bus.hwlp_jump_o      = jump;
  assign bus.hwlp_stall_o     = ~rst & stall_raw;
  assign bus.hwlp_targ_addr_o = (~rst && any_match) ? bus.hwlp_start_addr_i[win] : 32'd0;

  always_comb begin
    bus.hwlp_dec_cnt_o = '0;
    for (int k = 0; k < N_REGS; k++) begin
      bus.hwlp_dec_cnt_o[k] = ~fifo_empty && (tag_q[0] == N_REG_BITS'(k));
    end
  end

  // --------------------------------------------------------------------------
  // FIFO update: drop the popped head and any entry of a rewritten loop,
  // compact the survivors in order, then append the new token.
  // --------------------------------------------------------------------------
  always_comb begin
    entry_keep = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      entry_keep[i] = entry_valid[i]
                    & ~(do_pop && (i == 0))
                    & ~(bus.hwlp_cnt_we_i && (tag_q[i] == bus.hwlp_regid_i));
    end
  end

  always_comb begin
    tag_d    = tag_q;
    fill_cnt = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_keep[i]) begin
        for (int j = 0; j < FIFO_DEPTH; j++) begin
          if (fill_cnt == CNT_W'(j)) begin
            tag_d[j] = tag_q[i];
          end
        end
        fill_cnt = fill_cnt + CNT_W'(1);
      end
    end
    if (push_keep) begin
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        if (fill_cnt == CNT_W'(j)) begin
          tag_d[j] = win;
        end
      end
      fill_cnt = fill_cnt + CNT_W'(1);
    end
  end

  // Token state machine. The next state follows the resulting occupancy;
  // flush overrides every push/pop and returns to EMPTY.
  always_comb begin
    cnt_d   = fill_cnt;
    state_d = state_q;
    if (bus.flush_i) begin
      cnt_d = '0;
    end
    if (cnt_d == '0) begin
      state_d = ST_EMPTY;
    end else if (cnt_d == CNT_W'(FIFO_DEPTH)) begin
      state_d = ST_FULL;
    end else begin
      state_d = ST_PART;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      cnt_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Taken-jump counter
  // --------------------------------------------------------------------------
`ifdef RISCV_HWLP_PERF_EN
  logic [31:0] jump_cnt_q, jump_cnt_d;

  always_comb begin
    jump_cnt_d = jump_cnt_q;
    if (jump) begin
      jump_cnt_d = jump_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jump_cnt_q <= 32'd0;
    end else begin
      jump_cnt_q <= jump_cnt_d;
    end
  end

  assign bus.hwlp_jump_cnt_o = jump_cnt_q;
`else
  assign bus.hwlp_jump_cnt_o = 32'd0;
`endif

endmodule
`default_nettype wire

// File: doc/riscv_hwloop_jump_ctrl.md
Name: riscv_hwloop_jump_ctrl

Overview:
- Sits between the IF stage and the hardware-loop register file.
- Compares the fetch PC against each loop's end address and redirects fetch to the loop start.
- Queues one counter-decrement token per end-of-body fetch.
- Releases each token to the register file (hwlp_dec_cnt_o) only when the matching instruction retires from ID. Fetch can therefore run ahead of the counter update without double-counting.

Parameters:
- N_REGS, 2, number of hardware loops; index 0 is the innermost loop and has the highest priority.
- N_REG_BITS, $clog2(N_REGS), width of the loop index.
- FIFO_DEPTH, 2, number of pending decrement tokens (fetch run-ahead).

Ports:
- clk  in  1  clock
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- current_pc_i  in  32  PC being fetched in IF
- if_valid_i  in  1  the fetch at current_pc_i is accepted this cycle
- id_valid_i  in  1  the instruction in ID retires this cycle; same signal as the register file's valid_i
- flush_i  in  1  branch or exception kill; drops all pending tokens
- hwlp_start_addr_i  in  N_REGS x 32  start address of each loop, from the loop registers
- hwlp_end_addr_i  in  N_REGS x 32  end address of each loop
- hwlp_counter_i  in  N_REGS x 32  current count of each loop
- hwlp_cnt_we_i  in  1  a loop counter is written this cycle
- hwlp_regid_i  in  N_REG_BITS  index of the loop whose counter is written
- hwlp_jump_o  out  1  redirect fetch to hwlp_targ_addr_o
- hwlp_targ_addr_o  out  32  start address of the winning loop
- hwlp_dec_cnt_o  out  N_REGS  one-hot decrement request to the loop registers
- hwlp_stall_o  out  1  token FIFO is full; IF must hold
- hwlp_jump_cnt_o  out  32  count of taken loop jumps (see Optional Feature)

Behaviour:
- Reset: FIFO empty; all outputs 0. hwlp_jump_o and hwlp_stall_o are forced to 0 while rst is high.
- Pending count, per loop k: pend_k = number of valid FIFO entries tagged k (0..FIFO_DEPTH).
- Effective count, per loop k: eff_k = hwlp_counter_i[k] - pend_k, 32-bit unsigned. If pend_k > counter, eff_k = 0 (saturate, never wrap).
- Loop k is active when eff_k >= 1. It matches when active and current_pc_i == hwlp_end_addr_i[k]. The lowest matching index wins.
- Jump (combinational):
  - hwlp_jump_o = if_valid_i & match & (eff_win > 1).
  - hwlp_targ_addr_o = hwlp_start_addr_i[win] when a loop matches, else 0.
- Last iteration: when eff_win == 1 there is no jump, but a token is still pushed, so the counter reaches 0.
- Push: if_valid_i & match & !hwlp_stall_o pushes tag win into the FIFO.
- Pop: when the FIFO is non-empty, hwlp_dec_cnt_o = onehot(head tag); otherwise 0. id_valid_i pops the head.
- Push and pop in the same cycle are both performed; occupancy is unchanged, including when the FIFO is full.
- Full: hwlp_stall_o = full & !id_valid_i. No push occurs while stalled.
- Empty: no pop occurs; hwlp_dec_cnt_o = 0, even if id_valid_i is high.
- Flush: flush_i empties the FIFO at the next edge. It overrides push and pop in the same cycle. hwlp_dec_cnt_o in the flush cycle is still driven from the head.
- Counter write: hwlp_cnt_we_i invalidates every entry tagged hwlp_regid_i and compacts the remaining entries in order. A same-cycle push for that loop is also dropped.
- Token state machine: EMPTY -> PART (push) -> FULL (push); FULL -> PART (pop); PART -> EMPTY (pop). Flush goes to EMPTY from any state.
- Reset asserted mid-operation clears everything immediately; in-flight tokens are lost, with no decrement.

Optional Feature:
- Macro: RISCV_HWLP_PERF_EN.
- Defined: hwlp_jump_cnt_o is a 32-bit counter that increments on every cycle with hwlp_jump_o = 1. It wraps at 2^32 and clears on reset.
- Undefined: the counter logic is not instantiated and hwlp_jump_cnt_o is tied to 0.

Test Plan:
- Counter write, then fetches: loop0 start=0x100, end=0x10C, write counter0=3; fetch 0x10C three times, each with id_valid one cycle later -> jump, jump, no jump; hwlp_dec_cnt_o = 01 three times.
- Run-ahead stall: counter0=5, fetch 0x10C twice with id_valid low -> two jumps; a third fetch of 0x10C with id_valid low -> hwlp_stall_o = 1, no push. Assert id_valid -> stall drops, push and pop occur together.
- Nesting: loops 0 and 1 share end=0x200, counter0=1, counter1=4; fetch 0x200 -> no jump (loop0 wins, last iteration), token tagged 0. Next fetch of 0x200 -> eff0=0, so loop1 wins: jump to start1, token tagged 1.
- Flush: two tokens pending, flush_i together with id_valid_i -> FIFO empty next cycle; hwlp_dec_cnt_o = 0 afterwards.
- Counter write against pending tokens: token for loop1 pending, write counter1=10 -> token dropped, no decrement; next fetch of end1 uses eff1 = 10.
- Perf counter: with RISCV_HWLP_PERF_EN, 7 taken jumps -> hwlp_jump_cnt_o = 7; assert rst mid-run -> 0.
